line_mem_responder: RTL and testbench
=====================================

# line_mem_responder

Memory-side responder for the 64-bit line bus driven by the L1 set-associative cache's DRAM port (`m_bus_*`). It accepts one line request at a time and services it in 64-bit beats. A read returns eight beats after a fixed latency. A write collects eight data beats and commits them as one 512-bit line. It replaces the external DRAM model in unit and integration benches and serves as the backing store for cache bring-up.

## Interface
- `BUS_DATA_WIDTH`, default 64: bus beat width; fixed at 64.
- `BUS_TAG_WIDTH`, default 13: request tag width. Bit 12 is the op: 1 = read, 0 = write.
- `LINE_BITS`, default 512: line size, equal to 8 beats.
- `MEM_LINES`, default 256: number of stored lines; must be a power of 2.
- `READ_LATENCY`, default 4: idle cycles between the request ack and the first read beat; range 0..15.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `m_bus_reqcyc`, in, 1: request valid. Carries the address/tag beat first; for writes, also each data beat.
- `m_bus_reqack`, out, 1: one-cycle acknowledge of the request beat or of a data beat.
- `m_bus_req`, in, 64: byte address on the request beat; write data on data beats.
- `m_bus_reqtag`, in, 13: request tag; sampled on the request beat only.
- `m_bus_respcyc`, out, 1: read beat valid.
- `m_bus_respack`, in, 1: initiator accepts the current read beat.
- `m_bus_resp`, out, 64: read beat data.
- `m_bus_resptag`, out, 13: tag latched from the request.

## Operation
- **Storage:** `MEM_LINES` × 512-bit array.
  - Line index = `addr[6+log2(MEM_LINES)-1:6]`. Higher address bits are ignored, so addresses wrap modulo the array size.
  - `addr[5:0]` is ignored; transfers are always line-aligned.
  - Beat k maps to bits `[64k+63:64k]`. Beats always go in order 0→7.
- **Array contents:** zero at time 0. Reset does not clear them.
- **States and transitions:**
  - **IDLE:** when `reqcyc`=1, latch the address index and tag, then go to ACK.
  - **ACK:** `reqack`=1 for this one cycle.
    - Tag bit 12 = 0: go to WRDATA with beat counter = 0.
    - Tag bit 12 = 1 and `READ_LATENCY`=0: go to RESP.
    - Tag bit 12 = 1 and `READ_LATENCY`>0: go to WAIT with the latency counter loaded.
  - **WAIT:** decrement the latency counter each cycle. Go to RESP after `READ_LATENCY` cycles in WAIT.
  - **RESP:** `respcyc`=1, `resp` = line beat[cnt], `resptag` = latched tag.
    - `respack`=1 in the same cycle: cnt+1, and the next beat is presented the following cycle.
    - `respack`=0: hold the beat and all outputs stable.
    - `respack` on beat 7: cnt := 0, go to IDLE.
  - **WRDATA:** when `reqcyc`=1, capture `m_bus_req` into buffer beat[cnt] and go to WRACK. Otherwise wait.
  - **WRACK:** `reqack`=1 for one cycle.
    - Beat 7: go to COMMIT.
    - Otherwise: cnt+1, back to WRDATA.
  - **COMMIT:** write the full 512-bit buffer into the array at the latched index, then go to IDLE.
- **Boundary conditions:**
  - `reqcyc` is ignored in ACK, WAIT, RESP, WRACK and COMMIT; no ack is produced there.
  - `respack` is ignored outside RESP.
  - A partial write (reset, or the initiator stalling forever) never modifies the array; only COMMIT writes.
  - A read in the cycle after COMMIT returns the newly written line. Last write wins for the same index.
  - The beat counter is 3 bits wide and never increments past 7.
- **Reset:**
  - Next state is IDLE; counters clear.
  - `reqack`, `respcyc`, `resp` and `resptag` are all 0 and are registered outputs.
  - Reset in any state, including mid-burst, takes effect at that edge. There is no ack or response afterwards.

## Timing
- Request sampled at edge E0 → `reqack` high in the cycle after E0, for exactly 1 cycle.
- Read: first `respcyc` appears `READ_LATENCY`+1 cycles after the `reqack` cycle starts. With default 4, that is the 6th cycle after the request is sampled.
- A read with `respack` held high takes 8 consecutive beat cycles; IDLE is re-entered the cycle after beat 7.
- Write: minimum 2 cycles per beat (WRDATA + WRACK). Best case from request sample to IDLE: 1 (ACK) + 16 + 1 (COMMIT) = 18 cycles.
- `resp` and `resptag` are 0 whenever `respcyc`=0.

## Test plan
- **Reset then idle:** assert reset 2 cycles with `reqcyc`=1 → all outputs 0, no `reqack` until the cycle after reset is released plus one.
- **Read of unwritten memory:** read at addr `0x1040` → `reqack` pulse, then 8 beats of 0 with `resptag`=`0x1000|tag`. First beat exactly 5 cycles after the ack cycle; back-to-back with `respack` held at 1.
- **Write then read:** write to `0x80` with beats `0x11..0x88` (beat k = `0x11*(k+1)`), then read `0x80` → beats return `0x11,0x22,…,0x88` in order. Read of `0x80+MEM_LINES*64` returns the same data (wrap).
- **Read backpressure:** drop `respack` for 3 cycles on beat 2 → beat 2 data and tag held stable. Resumes with beat 3, no beat skipped or repeated.
- **Write stall:** stall `reqcyc` 4 cycles between beats 4 and 5 → no `reqack` during the stall; the final line is intact.
- **Reset mid-write:** reset after beat 5 of a write to `0x200` → next read of `0x200` returns the previous contents. A request issued in the busy window receives no `reqack`.

Source files
------------

// File: rtl/line_mem_responder.sv
// Memory-side responder for the 64-bit line bus. Accepts one line request at
// a time: reads return eight beats after a fixed latency, writes collect eight
// beats into a buffer and commit them to the array as one 512-bit line.
module line_mem_responder #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned LINE_BITS      = 512,
  parameter int unsigned MEM_LINES      = 256,
  parameter int unsigned READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m_bus_reqcyc,
  output logic                      m_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  output logic                      m_bus_respcyc,
  input  logic                      m_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag
);

  localparam int unsigned IdxW = $clog2(MEM_LINES);

  typedef enum logic [2:0] {
    StIdle, StAck, StWait, StResp, StWrData, StWrAck, StCommit
  } state_e;

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [3:0]                 lat_q, lat_d;
  logic [LINE_BITS-1:0]       wbuf_q;
  logic                       reqack_d, respcyc_d;
  logic [BUS_DATA_WIDTH-1:0]  resp_d;
  logic [BUS_TAG_WIDTH-1:0]   resptag_d;

  // Backing store; reset deliberately leaves contents untouched.
  logic [LINE_BITS-1:0]       mem_q [MEM_LINES];

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    unique case (state_q)
      StIdle: begin
        if (m_bus_reqcyc) begin
          idx_d   = m_bus_req[6 +: IdxW];
          tag_d   = m_bus_reqtag;
          state_d = StAck;
        end
      end
      StAck: begin
        cnt_d = 3'd0;
        if (!tag_q[BUS_TAG_WIDTH-1]) begin
          state_d = StWrData;
        end else if (READ_LATENCY == 0) begin
          state_d = StResp;
        end else begin
          lat_d   = 4'(READ_LATENCY - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (lat_q == 4'd0) state_d = StResp;
        else               lat_d   = lat_q - 4'd1;
      end
      StResp: begin
        if (m_bus_respack) begin
          if (cnt_q == 3'd7) begin
            cnt_d   = 3'd0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StWrData: begin
        if (m_bus_reqcyc) state_d = StWrAck;
      end
      StWrAck: begin
        if (cnt_q == 3'd7) begin
          state_d = StCommit;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = StWrData;
        end
      end
      StCommit: begin
        cnt_d   = 3'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the upcoming state.
    reqack_d  = (state_d == StAck) || (state_d == StWrAck);
    respcyc_d = (state_d == StResp);
    resp_d    = respcyc_d ? mem_q[idx_d][{cnt_d, 6'd0} +: BUS_DATA_WIDTH] : '0;
    resptag_d = respcyc_d ? tag_d : '0;
  end

  // Control state and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      tag_q         <= '0;
      cnt_q         <= 3'd0;
      lat_q         <= 4'd0;
      m_bus_reqack  <= 1'b0;
      m_bus_respcyc <= 1'b0;
      m_bus_resp    <= '0;
      m_bus_resptag <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tag_q         <= tag_d;
      cnt_q         <= cnt_d;
      lat_q         <= lat_d;
      m_bus_reqack  <= reqack_d;
      m_bus_respcyc <= respcyc_d;
      m_bus_resp    <= resp_d;
      m_bus_resptag <= resptag_d;
    end
  end

  // Write-beat capture into the line buffer.
  always_ff @(posedge clk) begin
    if (!reset && state_q == StWrData && m_bus_reqcyc) begin
      wbuf_q[{cnt_q, 6'd0} +: BUS_DATA_WIDTH] <= m_bus_req;
    end
  end

  // Whole-line commit; the only path that modifies the array.
  always_ff @(posedge clk) begin
    if (!reset && state_q == StCommit) begin
      mem_q[idx_q] <= wbuf_q;
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: a line-level memory model and an
// expected-beat queue, checked every cycle by one monitor process.
module tb_line_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_bus_reqcyc;
  logic        m_bus_reqack;
  logic [63:0] m_bus_req;
  logic [12:0] m_bus_reqtag;
  logic        m_bus_respcyc;
  logic        m_bus_respack;
  logic [63:0] m_bus_resp;
  logic [12:0] m_bus_resptag;

  line_mem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .m_bus_reqcyc  (m_bus_reqcyc),
    .m_bus_reqack  (m_bus_reqack),
    .m_bus_req     (m_bus_req),
    .m_bus_reqtag  (m_bus_reqtag),
    .m_bus_respcyc (m_bus_respcyc),
    .m_bus_respack (m_bus_respack),
    .m_bus_resp    (m_bus_resp),
    .m_bus_resptag (m_bus_resptag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [12:0] tag;
  } beat_t;

  int          errors = 0;
  int          checks = 0;
  logic        mon_en = 1'b0;
  beat_t       exp_q[$];
  logic [511:0] model_mem [256];
  logic [63:0] got_beats [8];
  logic [12:0] got_tag;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every sampled cycle the response outputs must match the model.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (m_bus_respcyc) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m_bus_respcyc), 64'd0);
        end else begin
          chk("resp_data", m_bus_resp, exp_q[0].data);
          chk("resp_tag", 64'(m_bus_resptag), 64'(exp_q[0].tag));
          if (m_bus_respack) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_resp", m_bus_resp, 64'd0);
        chk("idle_resptag", 64'(m_bus_resptag), 64'd0);
      end
    end
  end

  task automatic push_read(input logic [63:0] addr, input logic [11:0] tag);
    logic [511:0] line;
    line = model_mem[(addr >> 6) & 64'd255];
    for (int k = 0; k < 8; k++) exp_q.push_back({line[k*64 +: 64], 1'b1, tag});
  endtask

  // Called in the ack cycle of a read; consumes all eight beats.
  task automatic read_body(input int stall_beat, input int stall_n, input bit busy);
    int n = 0;
    m_bus_respack = 1'b1;
    if (busy) begin
      m_bus_reqcyc = 1'b1;
      m_bus_req    = 64'h200;
      m_bus_reqtag = 13'h0123;
    end
    while (!m_bus_respcyc && n < 20) begin
      tick();
      n++;
      if (busy && !m_bus_respcyc) chk("busy_no_ack", 64'(m_bus_reqack), 64'd0);
    end
    m_bus_reqcyc = 1'b0;
    chk("read_latency", 64'(n), 64'd5);
    for (int k = 0; k < 8; k++) begin
      chk("beat_valid", 64'(m_bus_respcyc), 64'd1);
      got_beats[k] = m_bus_resp;
      got_tag      = m_bus_resptag;
      if (k == stall_beat) begin
        m_bus_respack = 1'b0;
        repeat (stall_n) begin
          tick();
          chk("hold_valid", 64'(m_bus_respcyc), 64'd1);
          chk("hold_data", m_bus_resp, got_beats[k]);
        end
        m_bus_respack = 1'b1;
      end
      tick();
    end
    m_bus_respack = 1'b0;
    chk("idle_after_read", 64'(m_bus_respcyc), 64'd0);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [11:0] tag,
                         input int stall_beat, input int stall_n, input bit busy);
    m_bus_reqcyc = 1'b1;
    m_bus_req    = addr;
    m_bus_reqtag = {1'b1, tag};
    tick();
    chk("rd_req_ack", 64'(m_bus_reqack), 64'd1);
    m_bus_reqcyc = 1'b0;
    push_read(addr, tag);
    read_body(stall_beat, stall_n, busy);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [11:0] tag,
                          input logic [63:0] base, input logic [63:0] step,
                          input int stall_after, input int stall_n, input int reset_after);
    logic [511:0] line;
    logic [63:0]  d;
    int           n;
    bit           stalled = 1'b0;
    line = model_mem[(addr >> 6) & 64'd255];
    m_bus_reqcyc = 1'b1;
    m_bus_req    = addr;
    m_bus_reqtag = {1'b0, tag};
    tick();
    chk("wr_req_ack", 64'(m_bus_reqack), 64'd1);
    m_bus_reqcyc = 1'b0;
    for (int k = 0; k < 8; k++) begin
      d = base + step * 64'(k);
      m_bus_reqcyc = 1'b1;
      m_bus_req    = d;
      n = 0;
      do begin
        tick();
        n++;
      end while (!m_bus_reqack && n < 10);
      chk("wr_beat_cycles", 64'(n), stalled ? 64'd1 : 64'd2);
      m_bus_reqcyc = 1'b0;
      stalled = 1'b0;
      line[k*64 +: 64] = d;
      if (k == reset_after) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_no_ack", 64'(m_bus_reqack), 64'd0);
        chk("rst_no_resp", 64'(m_bus_respcyc), 64'd0);
        return;
      end
      if (k == stall_after && stall_n > 0) begin
        repeat (stall_n) begin
          tick();
          chk("stall_no_ack", 64'(m_bus_reqack), 64'd0);
        end
        stalled = 1'b1;
      end
    end
    tick();
    chk("commit_no_ack", 64'(m_bus_reqack), 64'd0);
    tick();
    model_mem[(addr >> 6) & 64'd255] = line;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    m_bus_respack = 1'b0;

    // Reset held two cycles with a read request pending.
    reset        = 1'b1;
    m_bus_reqcyc = 1'b1;
    m_bus_req    = 64'h1040;
    m_bus_reqtag = 13'h1055;
    repeat (2) begin
      tick();
      chk("rst_reqack", 64'(m_bus_reqack), 64'd0);
      chk("rst_respcyc", 64'(m_bus_respcyc), 64'd0);
      chk("rst_resp", m_bus_resp, 64'd0);
      chk("rst_resptag", 64'(m_bus_resptag), 64'd0);
    end
    reset = 1'b0;
    mon_en = 1'b1;
    chk("release_no_ack", 64'(m_bus_reqack), 64'd0);
    tick();
    chk("first_ack", 64'(m_bus_reqack), 64'd1);
    m_bus_reqcyc = 1'b0;
    push_read(64'h1040, 12'h055);
    read_body(-1, 0, 1'b0);
    chk("unwritten_beat0", got_beats[0], 64'd0);
    chk("unwritten_beat7", got_beats[7], 64'd0);
    chk("unwritten_tag", 64'(got_tag), 64'h1055);

    // Write then read back, plus the aliased address one array-size higher.
    do_write(64'h80, 12'h00a, 64'h11, 64'h11, -1, 0, -1);
    do_read(64'h80, 12'h00b, -1, 0, 1'b0);
    for (int k = 0; k < 8; k++) chk("wr_rd_literal", got_beats[k], 64'h11 * 64'(k + 1));
    do_read(64'h80 + 64'd256 * 64'd64, 12'h00c, 2, 3, 1'b0);
    chk("wrap_beat2", got_beats[2], 64'h33);
    chk("wrap_beat3", got_beats[3], 64'h44);
    chk("wrap_beat7", got_beats[7], 64'h88);

    // Write stall between beats 4 and 5.
    do_write(64'h300, 12'h011, 64'h1000, 64'h100, 4, 4, -1);
    do_read(64'h300, 12'h012, -1, 0, 1'b0);
    chk("stall_beat5", got_beats[5], 64'h1500);

    // Full write to 0x200, then a write aborted by reset after beat 5.
    do_write(64'h200, 12'h020, 64'ha0, 64'h1, -1, 0, -1);
    do_write(64'h200, 12'h021, 64'hdead0000, 64'h1, -1, 0, 5);
    do_read(64'h200, 12'h022, -1, 0, 1'b1);
    chk("abort_beat0", got_beats[0], 64'ha0);
    chk("abort_beat5", got_beats[5], 64'ha5);

    // Last write wins for the same index.
    do_write(64'h4200, 12'h030, 64'h5a5a0000, 64'h3, -1, 0, -1);
    do_read(64'h200, 12'h031, 0, 2, 1'b0);
    chk("last_wins_beat1", got_beats[1], 64'h5a5a0003);

    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
